data_mem_dma: RTL and testbench

- Initiator-side block copy engine that drives the data memory's port set (A, WD, ByteORword, ByteORwordS, MemWrite, EN, RD).
- Copies Length bytes from SrcAddr to DstAddr inside the same data memory.
- Uses word accesses when both pointers are word-aligned and at least 4 bytes remain; otherwise uses byte accesses.
- Sits beside the datapath as a memory master. The arbitration mux into the memory lives outside this block.

---
 rtl/data_mem_dma.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_dma.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_dma.sv
// Block copy engine mastering the data memory port set.
// Word accesses while both pointers are aligned and 4+ bytes remain, byte accesses otherwise.
module data_mem_dma #(
    parameter int unsigned SIZE = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [31:0] SrcAddr,
    input  logic [31:0] DstAddr,
    input  logic [15:0] Length,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        ByteORword,
    output logic        ByteORwordS,
    output logic        MemWrite,
    output logic        EN,
    input  logic [31:0] RD
);

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 16;
    localparam logic [AW:0] BYTE_LIMIT = (AW + 1)'(SIZE * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [AW-1:0] buf_q, buf_d;
    logic          mode_q, mode_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] wd_q, wd_d;
    logic          bw_q, bw_d;
    logic          bws_q, bws_d;
    logic          mw_q, mw_d;
    logic          en_q, en_d;

    logic [AW:0]   src_end_c;
    logic [AW:0]   dst_end_c;
    logic [AW-1:0] step_c;
    logic          byte_mode_c;

    assign src_end_c = {1'b0, SrcAddr} + (AW + 1)'(Length);
    assign dst_end_c = {1'b0, DstAddr} + (AW + 1)'(Length);
    assign step_c    = mode_q ? AW'(1) : AW'(4);

    // Next state, then registered outputs derived from the state being entered
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        buf_d       = buf_q;
        mode_d      = mode_q;
        err_d       = err_q;
        a_d         = a_q;
        wd_d        = wd_q;
        bw_d        = bw_q;
        bws_d       = bws_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mw_d        = 1'b0;
        en_d        = 1'b0;
        byte_mode_c = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    src_d = SrcAddr;
                    dst_d = DstAddr;
                    rem_d = Length;
                    err_d = 1'b0;
                    if ((src_end_c > BYTE_LIMIT) || (dst_end_c > BYTE_LIMIT)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (Length == LW'(0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                buf_d   = RD;
                state_d = S_WR;
            end
            S_WR: begin
                src_d   = src_q + step_c;
                dst_d   = dst_q + step_c;
                rem_d   = rem_q - LW'(step_c);
                state_d = (rem_d == LW'(0)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Access width for the unit about to start is fixed here and held through its WR
        case (state_d)
            S_RD: begin
                byte_mode_c = !((src_d[1:0] == 2'b00) && (dst_d[1:0] == 2'b00) &&
                                (rem_d >= LW'(4)));
                mode_d = byte_mode_c;
                busy_d = 1'b1;
                en_d   = 1'b1;
                a_d    = src_d;
                bw_d   = byte_mode_c;
            end
            S_WR: begin
                busy_d = 1'b1;
                en_d   = 1'b1;
                mw_d   = 1'b1;
                a_d    = dst_d;
                wd_d   = buf_d;
                bw_d   = mode_d;
                bws_d  = mode_d;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            bw_q    <= 1'b0;
            bws_q   <= 1'b0;
            mw_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            bw_q    <= bw_d;
            bws_q   <= bws_d;
            mw_q    <= mw_d;
            en_q    <= en_d;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Error       = err_q;
    assign A           = a_q;
    assign WD          = wd_q;
    assign ByteORword  = bw_q;
    assign ByteORwordS = bws_q;
    assign MemWrite    = mw_q;
    assign EN          = en_q;

endmodule

// File: tb/tb_data_mem_dma.sv
// Scoreboarded bench for data_mem_dma: little-endian byte memory model, expected
// bus transactions queued per copy and popped as the engine accesses memory.
module tb_data_mem_dma;

    localparam int unsigned SIZE = 32;
    localparam int unsigned NB   = SIZE * 4;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic [31:0] SrcAddr;
    logic [31:0] DstAddr;
    logic [15:0] Length;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [31:0] A;
    logic [31:0] WD;
    logic        ByteORword;
    logic        ByteORwordS;
    logic        MemWrite;
    logic        EN;
    logic [31:0] RD;

    data_mem_dma #(.SIZE(SIZE)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Start       (Start),
        .SrcAddr     (SrcAddr),
        .DstAddr     (DstAddr),
        .Length      (Length),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error),
        .A           (A),
        .WD          (WD),
        .ByteORword  (ByteORword),
        .ByteORwordS (ByteORwordS),
        .MemWrite    (MemWrite),
        .EN          (EN),
        .RD          (RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic        mode;
        logic [31:0] wd;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] mem  [NB];
    logic [7:0] gold [NB];
    logic       load_mem;
    int         checks;
    int         failures;
    int         done_cnt;

    // Memory model: combinational read, byte reads zero-extended
    logic [6:0] ai0, ai1, ai2, ai3;
    assign ai0 = 7'(A);
    assign ai1 = ai0 + 7'd1;
    assign ai2 = ai0 + 7'd2;
    assign ai3 = ai0 + 7'd3;
    assign RD  = ByteORword ? {24'h0, mem[ai0]} : {mem[ai3], mem[ai2], mem[ai1], mem[ai0]};

    always @(posedge CLK) begin
        if (load_mem) begin
            for (int i = 0; i < NB; i++) mem[i] <= gold[i];
        end else if (EN && MemWrite) begin
            mem[ai0] <= WD[7:0];
            if (!ByteORwordS) begin
                mem[ai1] <= WD[15:8];
                mem[ai2] <= WD[23:16];
                mem[ai3] <= WD[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: every enabled access must match the next queued transaction
    always @(negedge CLK) begin
        txn_t t;
        if (Done) done_cnt++;
        if (EN && !RST) begin
            if (exp_q.size() == 0) begin
                check("unexpected_access", 32'(A), 32'hFFFF_FFFF);
            end else begin
                t = exp_q.pop_front();
                check("addr", A, t.a);
                check("memwrite", 32'(MemWrite), 32'(t.we));
                check("rd_mode", 32'(ByteORword), 32'(t.mode));
                if (t.we) begin
                    check("wr_mode", 32'(ByteORwordS), 32'(t.mode));
                    check("wdata", WD, t.wd);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_error", 32'(Error), 0);
        check("rst_en", 32'(EN), 0);
        check("rst_memwrite", 32'(MemWrite), 0);
        check("rst_a", A, 0);
        check("rst_wd", WD, 0);
        check("rst_bw", 32'(ByteORword), 0);
        check("rst_bws", 32'(ByteORwordS), 0);
    endtask

    task automatic check_mem(input string tag);
        int nbad = 0;
        for (int i = 0; i < NB; i++) if (mem[i] !== gold[i]) nbad++;
        check(tag, 32'(nbad), 0);
    endtask

    // abort_cyc != 0: assert RST mid-cycle at that cycle after the Start edge
    task automatic run_copy(input int src, input int dst, input int len,
                            input bit poke, input int abort_cyc);
        logic [31:0] s = 32'(src);
        logic [31:0] d = 32'(dst);
        int          rem = len;
        int          units = 0;
        int          cyc = 0;
        int          busy_n = 0;
        int          d0;
        bit          exp_err;
        bit          bmode;
        int          n;
        logic [31:0] data;

        exp_err = (longint'(src) + len > NB) || (longint'(dst) + len > NB);
        if (!exp_err) begin
            while (rem > 0) begin
                bmode = !((s[1:0] == 2'b00) && (d[1:0] == 2'b00) && (rem >= 4));
                n     = bmode ? 1 : 4;
                data  = bmode ? {24'h0, gold[s]} :
                        {gold[s + 3], gold[s + 2], gold[s + 1], gold[s]};
                exp_q.push_back('{a: s, we: 1'b0, mode: bmode, wd: 32'h0});
                exp_q.push_back('{a: d, we: 1'b1, mode: bmode, wd: data});
                if (abort_cyc == 0 || units < (abort_cyc - 1) / 2)
                    for (int k = 0; k < n; k++) gold[d + k] = data[8*k +: 8];
                s = s + 32'(n);
                d = d + 32'(n);
                rem -= n;
                units++;
            end
        end

        @(negedge CLK);
        SrcAddr = 32'(src);
        DstAddr = 32'(dst);
        Length  = 16'(len);
        Start   = 1'b1;
        d0      = done_cnt;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                Start = poke;
                if (poke) begin
                    SrcAddr = 32'h40;
                    DstAddr = 32'h4;
                    Length  = 16'd3;
                end
            end
            if (cyc == 2) Start = 1'b0;
            if (Busy) busy_n++;
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                #2 RST = 1'b1;
                #1 check_reset_outputs();
                exp_q.delete();
                repeat (3) @(negedge CLK);
                check("abort_no_done", 32'(done_cnt - d0), 0);
                RST = 1'b0;
                check_mem("abort_mem");
                return;
            end
            if (Done) break;
            if (cyc >= 300) begin
                check("done_timeout", 32'(cyc), 32'(2 * units + 1));
                break;
            end
        end
        check("latency", 32'(cyc), 32'(2 * units + 1));
        check("busy_cycles", 32'(busy_n), 32'(2 * units));
        check("error", 32'(Error), 32'(exp_err));
        @(negedge CLK);
        check("done_one_cycle", 32'(Done), 0);
        check("done_count", 32'(done_cnt - d0), 1);
        check("error_held", 32'(Error), 32'(exp_err));
        check("sb_empty", 32'(exp_q.size()), 0);
        check_mem("mem");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        RST      = 1'b1;
        Start    = 1'b0;
        SrcAddr  = '0;
        DstAddr  = '0;
        Length   = '0;
        for (int i = 0; i < NB; i++) gold[i] = 8'(i * 7 + 8'h35);
        for (int i = 0; i < 8; i++) gold[i] = 8'(8'h11 * (i + 1));
        load_mem = 1'b1;
        repeat (2) @(negedge CLK);
        load_mem = 1'b0;
        check_reset_outputs();
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        run_copy(0, 16, 8, 0, 0);
        run_copy(1, 20, 3, 0, 0);
        run_copy(0, 32, 6, 0, 0);
        run_copy(120, 0, 16, 0, 0);
        run_copy(0, 0, 0, 0, 0);
        run_copy(8, 41, 5, 0, 0);
        run_copy(0, 4, 8, 0, 0);
        run_copy(96, 0, 32, 0, 0);
        run_copy(0, 64, 32, 0, 4);
        run_copy(0, 64, 32, 0, 0);
        run_copy(16, 96, 8, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
